// File: rtl/fletcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fletcher_pkg
// Description : Definitions shared by the Fletcher checksum generator and
//               checker. It holds the default half-width (the data word
//               width), the end-around modulus and the frame state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fletcher_pkg;

    // Default data word width, which is half of a 32-bit checksum.
    localparam int              WidthHalf   = 16;

    // Modulus for the default width. The all-ones pattern is congruent to 0.
    localparam logic [WidthHalf-1:0] FLETCHER_MOD = {WidthHalf{1'b1}};

    // Frame sequencing states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_TRLB = 3'd2,
        ST_TRLA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fletcher_mod_add.sv
`default_nettype none
// ============================================================================
// Module      : fletcher_mod_add
// Description : Single-cycle combinational adder modulo (2^W - 1).
//               The operands are expected in [0, 2^W - 2]. The result is
//               kept in that range, so all-ones never appears on o_sum.
// Ports       : i_x, i_y  - operands, W bits each
//               o_sum     - (i_x + i_y) mod (2^W - 1)
// Revision    : 1.0 - initial release
// ============================================================================
module fletcher_mod_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic [W-1:0] o_sum
);

    localparam logic [W:0] C_MOD = {1'b0, {W{1'b1}}};

    logic [W:0] w_sum;

    assign w_sum = {1'b0, i_x} + {1'b0, i_y};

    // A sum at or above the modulus is always below 2^(W+1) - 1. Subtracting
    // the modulus therefore fits in W bits, and the truncated difference is exact.
    always_comb begin
        o_sum = w_sum[W-1:0];
        if (w_sum >= C_MOD) begin
            o_sum = w_sum[W-1:0] - {W{1'b1}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fletcher_checksum_checker.sv
`default_nettype none
// ============================================================================
// Module      : fletcher_checksum_checker
// Description : Receives a frame of len data words and then two trailer words
//               (expected b, then expected a). It computes the Fletcher
//               checksum {b,a} of the data and pulses done with a match
//               verdict.
//               Optional feature macro: FLETCHER_CHECKER_ERRCNT_EN adds an
//               8-bit saturating count of failed frames (err_count).
// Ports       : clk, rst_n         - clock and async active-low reset
//               start, len         - frame request and data word count
//               din, din_valid     - data/trailer word stream
//               din_ready          - word accepted when din_valid is also high
//               busy, done         - frame in progress / verdict pulse
//               ok, chk            - verdict and computed checksum {b,a}
//               err_count          - (optional) failed-frame counter
// Revision    : 1.0 - initial release
// ============================================================================
module fletcher_checksum_checker
    import fletcher_pkg::*;
#(
    parameter int Width    = 32,
    parameter int LenWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LenWidth-1:0]   len,
    input  logic [Width/2-1:0]    din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  ok,
    output logic [Width-1:0]      chk
`ifdef FLETCHER_CHECKER_ERRCNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam int Half = Width / 2;

    state_t                r_state;
    logic [Half-1:0]       r_a;
    logic [Half-1:0]       r_b;
    logic [Half-1:0]       r_exp_b;
    logic [LenWidth-1:0]   r_cnt;
    logic [LenWidth-1:0]   r_len;
    logic                  r_din_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ok;
    logic [Width-1:0]      r_chk;

    logic                  w_xfer;
    logic                  w_last;
    logic                  w_match;
    logic [Half-1:0]       w_a_next;
    logic [Half-1:0]       w_b_next;
    logic [Half-1:0]       w_din_canon;

    assign w_xfer = din_valid && r_din_ready;
    assign w_last = (r_cnt == (r_len - LenWidth'(1)));

    // All-ones is the second representation of zero in one's-complement
    // arithmetic. The running sums never hold it, so trailer words are folded
    // onto zero before they are compared.
    assign w_din_canon = (din == {Half{1'b1}}) ? '0 : din;

    // The verdict is formed while the TRLA word is on din.
    assign w_match = (r_exp_b == r_b) && (w_din_canon == r_a);

    // b accumulates the updated a within the same cycle, so the two adders
    // are chained.
    fletcher_mod_add #(.W(Half)) u_add_a (
        .i_x   (r_a),
        .i_y   (din),
        .o_sum (w_a_next)
    );

    fletcher_mod_add #(.W(Half)) u_add_b (
        .i_x   (r_b),
        .i_y   (w_a_next),
        .o_sum (w_b_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_exp_b     <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_din_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
            r_chk       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a         <= '0;
                        r_b         <= '0;
                        r_cnt       <= '0;
                        r_len       <= len;
                        r_ok        <= 1'b0;
                        r_chk       <= '0;
                        r_busy      <= 1'b1;
                        r_din_ready <= 1'b1;
                        r_state     <= (len == '0) ? ST_TRLB : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_a   <= w_a_next;
                        r_b   <= w_b_next;
                        r_cnt <= r_cnt + LenWidth'(1);
                        if (w_last) begin
                            r_state <= ST_TRLB;
                        end
                    end
                end
                ST_TRLB: begin
                    if (w_xfer) begin
                        r_exp_b <= w_din_canon;
                        r_state <= ST_TRLA;
                    end
                end
                ST_TRLA: begin
                    if (w_xfer) begin
                        r_ok        <= w_match;
                        r_chk       <= {r_b, r_a};
                        r_done      <= 1'b1;
                        r_din_ready <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_din_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FLETCHER_CHECKER_ERRCNT_EN
    logic [7:0] r_err_count;

    // Counts on the edge that raises done, so the count already includes the
    // current frame while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if ((r_state == ST_TRLA) && w_xfer && !w_match
                     && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign din_ready = r_din_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ok        = r_ok;
    assign chk       = r_chk;

endmodule
`default_nettype wire

// File: tb/tb_fletcher_checksum_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fletcher_checksum_checker
// Description : Directed self-checking bench for fletcher_checksum_checker.
//               Expected verdicts come from a reference model and are queued
//               when a frame is driven. They are popped when done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fletcher_checksum_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        busy;
    logic        done;
    logic        ok;
    logic [31:0] chk;
`ifdef FLETCHER_CHECKER_ERRCNT_EN
    logic [7:0]  err_count;
    int          err_exp;
`endif

    typedef struct {
        logic        ok;
        logic [31:0] chk;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] data_q[$];
    int          n_cmp;
    int          n_fail;

    fletcher_checksum_checker #(
        .Width    (32),
        .LenWidth (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .busy      (busy),
        .done      (done),
        .ok        (ok),
        .chk       (chk)
`ifdef FLETCHER_CHECKER_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: straightforward integer modulo arithmetic
    function automatic exp_t model(input int l, input logic [15:0] tb_w, input logic [15:0] ta_w);
        exp_t        r;
        int          a;
        int          b;
        logic [15:0] a16;
        logic [15:0] b16;
        int          eb;
        int          ea;
        a = 0;
        b = 0;
        for (int i = 0; i < l; i++) begin
            a = (a + int'(data_q[i])) % 65535;
            b = (b + a) % 65535;
        end
        eb  = (tb_w == 16'hFFFF) ? 0 : int'(tb_w);
        ea  = (ta_w == 16'hFFFF) ? 0 : int'(ta_w);
        a16 = a[15:0];
        b16 = b[15:0];
        r.ok  = (eb == b) && (ea == a);
        r.chk = {b16, a16};
        return r;
    endfunction

    // Offer one word. Inputs change 1 time unit after the rising edge, so the
    // registered din_ready is already stable when it is sampled.
    task automatic xfer(input logic [15:0] w, input string tag);
        int n;
        n         = 0;
        din       = w;
        din_valid = 1'b1;
        while (!din_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!din_ready) begin
            check({tag, "_ready_timeout"}, 64'(din_ready), 64'd1);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        din       = 16'h0;
    endtask

    task automatic pulse_start(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 16'h0;
    endtask

    task automatic frame(input string tag, input int l, input logic [15:0] tb_w,
                         input logic [15:0] ta_w, input bit toggle, input bit busy_start);
        exp_t e;
        e = model(l, tb_w, ta_w);
        sb_q.push_back(e);
        pulse_start(16'(l));
        check({tag, "_busy"}, 64'(busy), 64'd1);
        if (l == 0) begin
            // Zero-length frames go straight to the trailer state.
            check({tag, "_ready_trlb"}, 64'(din_ready), 64'd1);
        end
        if (busy_start) begin
            pulse_start(16'd5);
        end
        for (int i = 0; i < l; i++) begin
            if (toggle) begin
                din_valid = 1'b0;
                @(posedge clk); #1;
            end
            xfer(data_q[i], tag);
        end
        if (toggle) begin
            @(posedge clk); #1;
        end
        xfer(tb_w, tag);
        if (toggle) begin
            @(posedge clk); #1;
        end
        xfer(ta_w, tag);
        // done is expected in the cycle immediately after the TRLA transfer.
        check({tag, "_done"}, 64'(done), 64'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_ok"}, 64'(ok), 64'(e.ok));
            check({tag, "_chk"}, 64'(chk), 64'(e.chk));
`ifdef FLETCHER_CHECKER_ERRCNT_EN
            if (!e.ok && err_exp != 255) begin
                err_exp++;
            end
            check({tag, "_errcnt"}, 64'(err_count), 64'(err_exp));
`endif
        end
        @(posedge clk); #1;
        check({tag, "_done_clr"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_ok_hold"}, 64'(ok), 64'(e.ok));
        check({tag, "_chk_hold"}, 64'(chk), 64'(e.chk));
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
`ifdef FLETCHER_CHECKER_ERRCNT_EN
        err_exp   = 0;
`endif
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 16'h0;
        din       = 16'h0;
        din_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(din_ready), 64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_ok",    64'(ok),        64'd0);
        check("rst_chk",   64'(chk),       64'd0);
`ifdef FLETCHER_CHECKER_ERRCNT_EN
        check("rst_errcnt", 64'(err_count), 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame with a matching trailer
        data_q = '{16'h0001, 16'h0002};
        frame("basic", 2, 16'h0004, 16'h0003, 1'b0, 1'b0);

        // Same data with a wrong trailer
        frame("bad_trl", 2, 16'h0004, 16'h0004, 1'b0, 1'b0);

        // Wraparound and all-ones trailer folding
        data_q = '{16'hFFFF, 16'hFFFF};
        frame("wrap", 2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

        // Longer frame with mixed values
        data_q = '{16'h1234, 16'hFFFE, 16'h8000, 16'h0F0F, 16'hA5A5};
        begin
            exp_t m;
            m = model(5, 16'h0, 16'h0);
            frame("long", 5, m.chk[31:16], m.chk[15:0], 1'b0, 1'b0);
        end

        // Zero-length frame, with a start pulse while busy that must be ignored
        data_q = {};
        frame("len0", 0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("len0_no_restart", 64'(busy), 64'd0);

        // din_valid toggling every other cycle
        data_q = '{16'h0001, 16'h0002};
        frame("toggle", 2, 16'h0004, 16'h0003, 1'b1, 1'b0);

        // Reset asserted after the first data word, mid-frame
        pulse_start(16'd2);
        xfer(16'h0001, "midrst");
        check("midrst_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(din_ready), 64'd0);
        check("midrst_busy",  64'(busy),      64'd0);
        check("midrst_done",  64'(done),      64'd0);
        check("midrst_ok",    64'(ok),        64'd0);
        check("midrst_chk",   64'(chk),       64'd0);
`ifdef FLETCHER_CHECKER_ERRCNT_EN
        check("midrst_errcnt", 64'(err_count), 64'd0);
        err_exp = 0;
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame("post_rst", 2, 16'h0004, 16'h0003, 1'b0, 1'b0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: observed running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
